// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter and sequencer that shares a single mux_4x1 datapath
//   between four requesters (A=0, B=1, C=2, D=3). It holds a registered grant
//   index, drives the mux select from it and presents the selected word on a
//   valid/ready output channel. Each acceptance moves one beat.
//
//   Build option:
//     MUX_ARB_PRIO_EN  - when defined, source A has strict priority and B/C/D
//                        round-robin among themselves. When undefined, all four
//                        sources share a pure round-robin.
// -----------------------------------------------------------------------------

// Plain 4:1 word multiplexer. This is the only instance on the shared path.
module mux_4x1 #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    // Select one of four words. The path has no register.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

module mux_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // GRANT is encoded as 1, so out_valid is a direct decode of a flop bit.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic [1:0] last_reg, last_next;     // most recently accepted source

    logic       accept;                  // beat transfers on this edge
    logic       any_req;
    logic       arb_en;                  // an arbitration happens on this edge
    logic [1:0] arb_last;                // pointer that the search starts after
    logic [1:0] winner;

    assign out_valid = (state_reg == GRANT);
    assign accept    = out_valid & out_ready;
    assign any_req   = |req;
    assign arb_en    = (state_reg == IDLE) | accept;

    // On an accepting edge the beat just taken becomes "last" for this search.
    // The source just served therefore gets the lowest priority.
    assign arb_last  = accept ? sel_reg : last_reg;

`ifdef MUX_ARB_PRIO_EN
    // B/C/D keep their own pointer. An acceptance of A does not disturb their
    // rotation.
    logic [1:0] last_lo_reg, last_lo_next;
    logic [1:0] arb_lo;

    assign arb_lo = (accept && (sel_reg != 2'd0)) ? sel_reg : last_lo_reg;

    // Winner selection: A first, otherwise search B..D starting after arb_lo.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        winner = 2'd0;
        cand   = arb_lo;
        found  = 1'b0;
        if (!req[0]) begin
            for (int k = 0; k < 3; k++) begin
                cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
                if (!found && req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Update the B/C/D pointer only when one of them is accepted.
    always_comb begin
        last_lo_next = last_lo_reg;
        if (accept && (sel_reg != 2'd0)) begin
            last_lo_next = sel_reg;
        end
    end

    // Register the B/C/D pointer. Reset to D, so B is first among the three.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lo_reg <= 2'd3;
        end else begin
            last_lo_reg <= last_lo_next;
        end
    end
`else
    // Rotate the requests so that bit 0 is the source just after arb_last.
    // The lowest set bit of the rotated vector is then the winner's offset.
    logic [1:0] base;
    logic [3:0] rot_req;
    logic [1:0] offset;

    assign base = arb_last + 2'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req[base + 2'(gi)];
    end

    // Priority-encode the rotated requests. The lowest offset wins.
    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 2'(k);
            end
        end
    end

    assign winner = base + offset;
`endif

    // State register: grant, select and last-accepted pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            last_reg  <= 2'd3;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
        end
    end

    // Next-state logic.
    // An acceptance takes precedence over an abort. If the sink takes the beat
    // on the same edge that req drops, the beat has already been acknowledged.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (arb_en && any_req) begin
                    state_next = GRANT;
                    sel_next   = winner;
                end
            end
            GRANT: begin
                if (accept) begin
                    last_next = sel_reg;
                    if (any_req) begin
                        sel_next = winner;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!req[sel_reg]) begin
                    // Abort: the requester withdrew before it was served.
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. ack is one-hot on the accepted source.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
        assign ack[gi] = accept & (sel_reg == 2'(gi));
    end

    assign sel = sel_reg;

    mux_4x1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel_reg),
        .d0  (data_a),
        .d1  (data_b),
        .d2  (data_c),
        .d3  (data_d),
        .y   (out_data)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed scenarios and randomized traffic. A behavioural model of the
//   round-robin rules predicts the grant, ack and out_data of every cycle.
//   Honours MUX_ARB_PRIO_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] data_a, data_b, data_c, data_d;
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] dv [4];
    bit               m_valid;
    int               m_sel;
    int               m_last;
    int               m_lo;

    mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_c    (data_c),
        .data_d    (data_d),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pick the next source from the arbitration rules.
    function automatic int pick(input logic [3:0] r);
        int i;
`ifdef MUX_ARB_PRIO_EN
        if (r[0]) return 0;
        for (int k = 1; k <= 3; k++) begin
            i = ((m_lo - 1 + k) % 3) + 1;
            if (r[i]) return i;
        end
`else
        for (int k = 1; k <= 4; k++) begin
            i = (m_last + k) % 4;
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 0;
        m_last  = 3;
        m_lo    = 3;
    endtask

    // Advance the model by one clock edge, using the inputs sampled on it.
    task automatic model_edge(input logic [3:0] r, input logic rd);
        if (!m_valid) begin
            if (r != 4'b0) begin
                m_valid = 1'b1;
                m_sel   = pick(r);
            end
        end else if (rd) begin
            $display("beat src=%0d data=%h req=%b", m_sel, dv[m_sel], r);
            m_last = m_sel;
            if (m_sel != 0) m_lo = m_sel;
            if (r != 4'b0) m_sel = pick(r);
            else           m_valid = 1'b0;
        end else if (!r[m_sel]) begin
            m_valid = 1'b0;
        end
    endtask

    // One cycle. Drive the inputs at the negedge, compare against the model,
    // then let the edge happen.
    task automatic step(input logic [3:0] r, input logic rd);
        logic [3:0] exp_ack;
        req       = r;
        out_ready = rd;
        data_a    = dv[0];
        data_b    = dv[1];
        data_c    = dv[2];
        data_d    = dv[3];
        #1;
        exp_ack = (m_valid && rd) ? 4'(1 << m_sel) : 4'b0;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("sel", 32'(sel), 32'(m_sel));
            check("out_data", 32'(out_data), 32'(dv[m_sel]));
        end
        check("ack", 32'(ack), 32'(exp_ack));
        @(posedge clk);
        model_edge(r, rd);
        @(negedge clk);
    endtask

    // Asynchronous reset, asserted between clock edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) dv[i] = 16'h1000 * 16'(i + 1) + 16'h00a5;
        data_a = dv[0]; data_b = dv[1]; data_c = dv[2]; data_d = dv[3];
        model_reset();
        @(negedge clk);
        do_reset();

`ifdef MUX_ARB_PRIO_EN
        // A has priority while it keeps requesting.
        step(4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("prio_a", 32'(sel), 32'd0);
            step(4'b1111, 1'b1);
        end
        // Without A, the remaining three rotate starting at B.
        for (int k = 0; k < 6; k++) begin
            step(4'b1110, 1'b1);
            check("prio_bcd", 32'(sel), 32'(1 + (k % 3)));
        end
`else
        // Single requester A, re-granted every cycle.
        dv[0] = 16'h0180;
        step(4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("a_sel", 32'(sel), 32'd0);
            check("a_data", 32'(out_data), 32'h0180);
            check("a_valid", 32'(out_valid), 32'd1);
            step(4'b0001, 1'b1);
        end

        // All four requesting: grants in the order A, B, C, D, A...
        do_reset();
        step(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("rr_order", 32'(sel), 32'(k % 4));
            step(4'b1111, 1'b1);
        end

        // Backpressure holds the grant on B, then the rotation moves on to C.
        do_reset();
        step(4'b0110, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_sel", 32'(sel), 32'd1);
            step(4'b0110, 1'b0);
        end
        step(4'b0110, 1'b1);
        check("bp_next", 32'(sel), 32'd2);

        // Abort: A is served, then B is granted and withdraws unserved.
        // last stays at A, so B wins the following search. Had the abort
        // moved last to B, C would win instead.
        do_reset();
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        check("abort_grant", 32'(sel), 32'd1);
        step(4'b0000, 1'b0);
        check("abort_idle", 32'(out_valid), 32'd0);
        step(4'b1111, 1'b0);
        check("abort_regrant", 32'(sel), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd1);
`endif

        // Reset in the middle of a burst, then restart from A.
        do_reset();
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        do_reset();
        step(4'b1111, 1'b1);
        check("post_rst_sel", 32'(sel), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] r;
            logic       rd;
            for (int i = 0; i < 4; i++) dv[i] = 16'($urandom);
            r  = 4'($urandom);
            rd = ($urandom_range(3, 0) != 0);
            step(r, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
